alu_nibble_seq: RTL

Sequencer that performs a WORDBITS-wide add or subtract on a single external mc10181 4-bit ALU slice, one nibble per clock, least-significant nibble first. It chains the slice's COUT into the next nibble's CIN through a register, assembles the result, and reports carry, zero and (optionally) signed overflow. It sits between an operation requester and one mc10181 instance; an integration wrapper connects the slice ports.

---
 rtl/alu_nibble_seq_pkg.sv | 26 ++
 rtl/alu_nibble_seq_if.sv | 31 +++
 rtl/alu_nibble_seq.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/alu_nibble_seq_pkg.sv
// Shared types for the nibble-serial ALU sequencer: operation codes,
// mc10181 {M,S} function codes and the sequencer state encoding.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    ADC = 2'd2,
    SBC = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // {M,S} codes for the slice: A plus B plus CIN, and A minus B minus 1 plus CIN
  localparam logic [4:0] ADD_CODE = 5'b0_0110;
  localparam logic [4:0] SUB_CODE = 5'b0_1001;

  function automatic logic is_sub(op_t op);
    return (op == SUB) || (op == SBC);
  endfunction

endpackage

// File: rtl/alu_nibble_seq_if.sv
// Request/response bus between an operation requester and alu_nibble_seq.
// Operands and result use bit 0 as the MSB.
interface alu_seq_if
  import alu_seq_pkg::*;
#(
  parameter int WORDBITS = 36
) ();

  logic                req_valid;
  logic                req_ready;
  op_t                 req_op;
  logic [0:WORDBITS-1] req_a;
  logic [0:WORDBITS-1] req_b;
  logic                req_cin;
  logic                done;
  logic [0:WORDBITS-1] result;
  logic                carry;
  logic                zero;
  logic                ovf;

  modport master (
    output req_valid, req_op, req_a, req_b, req_cin,
    input  req_ready, done, result, carry, zero, ovf
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin,
    output req_ready, done, result, carry, zero, ovf
  );

endinterface

// File: rtl/alu_nibble_seq.sv
// Drives one external mc10181 slice a nibble per clock, LSB nibble first,
// chaining COUT back into CIN. Define ALU_NIBBLE_SEQ_OVF_EN to build signed overflow.
module alu_nibble_seq
  import alu_seq_pkg::*;
#(
  parameter int WORDBITS = 36
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus,
  output logic [0:3] S,
  output logic       M,
  output logic       CIN,
  output logic [0:3] A,
  output logic [0:3] B,
  input  logic [0:3] F,
  input  logic       COUT
);

  localparam int NNIB = WORDBITS / 4;
  localparam int KW   = (NNIB > 1) ? $clog2(NNIB) : 1;

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  op_t                 op_q, op_d;
  logic [0:WORDBITS-1] a_q, a_d;
  logic [0:WORDBITS-1] b_q, b_d;
  logic [0:WORDBITS-1] res_q, res_d;
  logic                cy_q, cy_d;
  logic                zero_q, zero_d;
`ifdef ALU_NIBBLE_SEQ_OVF_EN
  logic                ovf_q, ovf_d;
`endif

  logic                accept;
  logic                last_nib;
  int                  nib_base;
  logic [4:0]          ms_code;

  assign accept   = bus.req_valid && (state_q == IDLE);
  assign last_nib = (k_q == KW'(NNIB - 1));

  // Nibble k occupies the four bits starting at this index (bit 0 is the MSB)
  always_comb begin
    nib_base = WORDBITS - 4 - 4 * int'(k_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_nib) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    A         = 4'b0000;
    B         = 4'b0000;
    ms_code   = ADD_CODE;
    CIN       = 1'b0;
    if (state_q == RUN) begin
      A       = a_q[nib_base +: 4];
      B       = b_q[nib_base +: 4];
      ms_code = is_sub(op_q) ? SUB_CODE : ADD_CODE;
      CIN     = cy_q;
    end
  end

  assign {M, S}        = ms_code;
  assign bus.req_ready = (state_q == IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.carry     = cy_q;
  assign bus.zero      = zero_q;
`ifdef ALU_NIBBLE_SEQ_OVF_EN
  assign bus.ovf       = ovf_q;
`else
  assign bus.ovf       = 1'b0;
`endif

  always_comb begin
    k_d    = k_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    cy_d   = cy_q;
    zero_d = zero_q;
`ifdef ALU_NIBBLE_SEQ_OVF_EN
    ovf_d  = ovf_q;
`endif
    if (accept) begin
      k_d    = '0;
      op_d   = bus.req_op;
      a_d    = bus.req_a;
      b_d    = bus.req_b;
      res_d  = '0;
      zero_d = 1'b0;
`ifdef ALU_NIBBLE_SEQ_OVF_EN
      ovf_d  = 1'b0;
`endif
      case (bus.req_op)
        ADD:     cy_d = 1'b0;
        SUB:     cy_d = 1'b1;
        default: cy_d = bus.req_cin;
      endcase
    end else if (state_q == RUN) begin
      res_d[nib_base +: 4] = F;
      cy_d                 = COUT;
      k_d                  = last_nib ? '0 : k_q + 1'b1;
      if (last_nib) begin
        zero_d = (res_d == '0);
`ifdef ALU_NIBBLE_SEQ_OVF_EN
        // Final nibble carries the sign bit in F[0]
        if (is_sub(op_q)) begin
          ovf_d = (a_q[0] != b_q[0]) && (F[0] != a_q[0]);
        end else begin
          ovf_d = (a_q[0] == b_q[0]) && (F[0] != a_q[0]);
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_q    <= '0;
      op_q   <= ADD;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      cy_q   <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      k_q    <= k_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      cy_q   <= cy_d;
      zero_q <= zero_d;
    end
  end

`ifdef ALU_NIBBLE_SEQ_OVF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
`endif

endmodule
